// File: rtl/line_segment_queue_if.sv
// Segment push/draw/clear signal bundle for line_segment_queue.
// master: segment sources, drawer and clear engine. slave: the queue itself.
interface line_segment_queue_if #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned N_SRC   = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [N_SRC-1:0]           wr_valid;
    logic [N_SRC*4*COORD_W-1:0] wr_seg;
    logic [N_SRC-1:0]           wr_ready;
    logic [COORD_W-1:0]         x0;
    logic [COORD_W-1:0]         y0;
    logic [COORD_W-1:0]         x1;
    logic [COORD_W-1:0]         y1;
    logic                       draw_start;
    logic                       draw_done;
    logic                       clear_req;
    logic                       clear_active;
    logic                       clear_done;
    logic [CNT_W-1:0]           count;
    logic                       empty;
    logic                       full;

    modport master (
        output wr_valid, wr_seg, draw_done, clear_req, clear_done,
        input  wr_ready, x0, y0, x1, y1, draw_start, clear_active, count, empty, full
    );

    modport slave (
        input  wr_valid, wr_seg, draw_done, clear_req, clear_done,
        output wr_ready, x0, y0, x1, y1, draw_start, clear_active, count, empty, full
    );
endinterface

// File: rtl/line_segment_queue.sv
// Line-segment queue and drawer sequencer: round-robin multi-source push into one packed
// {x0,y0,x1,y1} FIFO, start/done handshake with the drawer, and a frame-clear that flushes
// pending segments.
// Optional feature: define LINE_SEGMENT_QUEUE_DEDUP_EN to acknowledge-but-drop a push equal to
// the most recently accepted segment.
module line_segment_queue #(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned N_SRC   = 2
) (
    input logic                 clk,
    input logic                 reset,
    line_segment_queue_if.slave bus
);
    localparam int unsigned SEG_W = 4 * COORD_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GP_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDraw, StClear} state_e;

    state_e           state_q, state_d;
    logic [SEG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [GP_W-1:0]  gp_q, gp_d;
    logic             clear_pending_q, clear_pending_d;
    logic [SEG_W-1:0] seg_out_q, seg_out_d;

    logic [N_SRC-1:0] grant;
    logic [SEG_W-1:0] win_seg;
    logic [GP_W-1:0]  win_next;
    logic             found, full, empty, accept, store, pop, enter_clear;

    // Round-robin pick: first pass scans gp..N_SRC-1, second pass wraps to 0..gp-1.
    always_comb begin
        grant    = '0;
        win_seg  = '0;
        win_next = '0;
        found    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (!found && bus.wr_valid[i] &&
                    ((p == 0) ? (i >= int'(gp_q)) : (i < int'(gp_q)))) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    win_seg  = bus.wr_seg[i*SEG_W +: SEG_W];
                    win_next = (i == int'(N_SRC) - 1) ? '0 : GP_W'(i + 1);
                end
            end
        end
    end

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    // A latched clear blocks pushes so the flush cannot race with new entries.
    assign accept = found && !full && !reset && (state_q != StClear) && !clear_pending_q;
    assign bus.wr_ready = accept ? grant : '0;

`ifdef LINE_SEGMENT_QUEUE_DEDUP_EN
    logic [SEG_W-1:0] last_q;
    logic             last_valid_q;

    assign store = accept && !(last_valid_q && (last_q == win_seg));

    // Track the most recently acknowledged segment from any source.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (enter_clear) begin
            last_valid_q <= 1'b0;
        end else if (accept) begin
            last_q       <= win_seg;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign store = accept;
`endif

    // Pop sequencer: clear wins over pending segments; coordinates load on the way into ISSUE.
    always_comb begin
        state_d     = state_q;
        seg_out_d   = seg_out_q;
        enter_clear = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_pending_q) begin
                    state_d     = StClear;
                    enter_clear = 1'b1;
                end else if (!empty) begin
                    state_d   = StIssue;
                    seg_out_d = mem_q[rd_ptr_q];
                end
            end
            StIssue: begin
                pop     = 1'b1;
                state_d = StDraw;
            end
            StDraw:  if (bus.draw_done) state_d = StIdle;
            StClear: if (bus.clear_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pointer, occupancy, grant pointer and clear latch next-state.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        gp_d            = accept ? win_next : gp_q;
        clear_pending_d = clear_pending_q | bus.clear_req;
        if (enter_clear) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            count_d         = '0;
            clear_pending_d = 1'b0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (store && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !store) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            gp_q            <= '0;
            clear_pending_q <= 1'b0;
            seg_out_q       <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            gp_q            <= gp_d;
            clear_pending_q <= clear_pending_d;
            seg_out_q       <= seg_out_d;
        end
    end

    // Segment storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= win_seg;
    end

    assign bus.x0           = seg_out_q[4*COORD_W-1 -: COORD_W];
    assign bus.y0           = seg_out_q[3*COORD_W-1 -: COORD_W];
    assign bus.x1           = seg_out_q[2*COORD_W-1 -: COORD_W];
    assign bus.y1           = seg_out_q[COORD_W-1:0];
    assign bus.draw_start   = (state_q == StIssue);
    assign bus.clear_active = (state_q == StClear);
    assign bus.count        = count_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
endmodule

// File: tb/tb_line_segment_queue.sv
// Directed self-checking bench for line_segment_queue (default COORD_W=11, DEPTH=16, N_SRC=2).
module tb_line_segment_queue;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned N_SRC   = 2;
    localparam int unsigned SEG_W   = 4 * COORD_W;
`ifdef LINE_SEGMENT_QUEUE_DEDUP_EN
    localparam logic [4:0] DUP_CNT = 5'd1;
`else
    localparam logic [4:0] DUP_CNT = 5'd2;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    line_segment_queue_if #(.COORD_W(COORD_W), .DEPTH(DEPTH), .N_SRC(N_SRC)) bus ();

    line_segment_queue #(.COORD_W(COORD_W), .DEPTH(DEPTH), .N_SRC(N_SRC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [SEG_W-1:0] mk(input int a, input int b, input int c, input int d);
        return {COORD_W'(a), COORD_W'(b), COORD_W'(c), COORD_W'(d)};
    endfunction

    function automatic logic [SEG_W-1:0] cur();
        return {bus.x0, bus.y0, bus.x1, bus.y1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Hold a push until acknowledged (bounded); returns whether it was taken.
    task automatic push_seg(input int src, input logic [SEG_W-1:0] s, output bit ok);
        ok = 1'b0;
        bus.wr_valid[src] = 1'b1;
        bus.wr_seg[src*SEG_W +: SEG_W] = s;
        for (int c = 0; c < 8; c++) begin
            #1;
            ok = bus.wr_ready[src];
            step();
            if (ok) break;
        end
        bus.wr_valid[src] = 1'b0;
    endtask

    task automatic test_reset();
        bus.wr_valid = 2'b11;
        bus.wr_seg   = {mk(1, 2, 3, 4), mk(5, 6, 7, 8)};
        reset = 1'b1;
        step();
        step();
        n_cmp++; if (bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 00", bus.wr_ready); end
        n_cmp++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", bus.empty, bus.full); end
        n_cmp++; if (bus.draw_start !== 1'b0 || bus.clear_active !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got ds=%b ca=%b want 0 0", bus.draw_start, bus.clear_active); end
        n_cmp++; if (cur() !== '0) begin n_fail++; $display("FAIL reset_coords: got %0h want 0", cur()); end
        bus.wr_valid = '0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.wr_valid = 2'b01;
        bus.wr_seg[SEG_W-1:0] = mk(10, 20, 30, 40);
        #1;
        n_cmp++; if (bus.wr_ready !== 2'b01) begin n_fail++; $display("FAIL basic_ready: got %b want 01", bus.wr_ready); end
        step();
        bus.wr_valid = '0;
        n_cmp++; if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL basic_count1: got %0d/%b want 1/0", bus.count, bus.empty); end
        n_cmp++; if (bus.draw_start !== 1'b0) begin n_fail++; $display("FAIL basic_early_start: got %b want 0", bus.draw_start); end
        step();
        n_cmp++; if (bus.draw_start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", bus.draw_start); end
        n_cmp++; if (cur() !== mk(10, 20, 30, 40)) begin n_fail++; $display("FAIL basic_coords: got %0h want %0h", cur(), mk(10, 20, 30, 40)); end
        step();
        n_cmp++; if (bus.draw_start !== 1'b0 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL basic_after_pop: got ds=%b cnt=%0d e=%b want 0 0 1", bus.draw_start, bus.count, bus.empty); end
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        step();
        n_cmp++; if (bus.draw_start !== 1'b0 || cur() !== mk(10, 20, 30, 40)) begin n_fail++; $display("FAIL basic_hold: got ds=%b coords=%0h want 0 %0h", bus.draw_start, cur(), mk(10, 20, 30, 40)); end
    endtask

    task automatic test_arbitration();
        logic [SEG_W-1:0] exp_seg [4];
        bit seen;
        exp_seg[0] = mk(1, 2, 3, 4);
        exp_seg[1] = mk(100, 200, 300, 400);
        exp_seg[2] = mk(5, 6, 7, 8);
        exp_seg[3] = mk(500, 600, 700, 800);
        apply_reset();
        bus.wr_valid = 2'b11;
        bus.wr_seg   = {exp_seg[1], exp_seg[0]};
        #1;
        n_cmp++; if (bus.wr_ready !== 2'b01) begin n_fail++; $display("FAIL arb_grant0: got %b want 01", bus.wr_ready); end
        step();
        bus.wr_seg = {exp_seg[1], exp_seg[2]};
        #1;
        n_cmp++; if (bus.wr_ready !== 2'b10) begin n_fail++; $display("FAIL arb_grant1: got %b want 10", bus.wr_ready); end
        step();
        bus.wr_seg = {exp_seg[3], exp_seg[2]};
        #1;
        n_cmp++; if (bus.wr_ready !== 2'b01) begin n_fail++; $display("FAIL arb_grant2: got %b want 01", bus.wr_ready); end
        n_cmp++; if (bus.draw_start !== 1'b1 || cur() !== exp_seg[0]) begin n_fail++; $display("FAIL arb_first_issue: got ds=%b %0h want 1 %0h", bus.draw_start, cur(), exp_seg[0]); end
        step();
        bus.wr_valid = 2'b10;
        #1;
        n_cmp++; if (bus.wr_ready !== 2'b10) begin n_fail++; $display("FAIL arb_grant3: got %b want 10", bus.wr_ready); end
        step();
        bus.wr_valid = '0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin
                seen = 1'b0;
                for (int c = 0; c < 8 && !seen; c++) begin
                    if (bus.draw_start === 1'b1) seen = 1'b1; else step();
                end
                n_cmp++; if (!seen) begin n_fail++; $display("FAIL arb_issue_timeout%0d: got no draw_start want draw_start", j); end
            end
            n_cmp++; if (cur() !== exp_seg[j]) begin n_fail++; $display("FAIL arb_order%0d: got %0h want %0h", j, cur(), exp_seg[j]); end
            if (j > 0) step();
            bus.draw_done = 1'b1;
            step();
            bus.draw_done = 1'b0;
        end
    endtask

    task automatic test_full();
        bit ok;
        bit seen;
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            push_seg(0, mk(k, k + 1, k + 2, k + 3), ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_push%0d: got no ready want ready", k); end
        end
        n_cmp++; if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin n_fail++; $display("FAIL full_state: got cnt=%0d f=%b e=%b want 16 1 0", bus.count, bus.full, bus.empty); end
        bus.wr_valid = 2'b01;
        bus.wr_seg[SEG_W-1:0] = mk(17, 18, 19, 20);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL full_block%0d: got %b want 00", c, bus.wr_ready); end
            step();
        end
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        n_cmp++; if (bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL full_idle_block: got %b want 00", bus.wr_ready); end
        step();
        n_cmp++; if (bus.draw_start !== 1'b1 || cur() !== mk(1, 2, 3, 4)) begin n_fail++; $display("FAIL full_issue: got ds=%b %0h want 1 %0h", bus.draw_start, cur(), mk(1, 2, 3, 4)); end
        n_cmp++; if (bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL full_pop_cycle_block: got %b want 00", bus.wr_ready); end
        step();
        n_cmp++; if (bus.count !== 5'd15 || bus.wr_ready !== 2'b01) begin n_fail++; $display("FAIL full_freed: got cnt=%0d rdy=%b want 15 01", bus.count, bus.wr_ready); end
        step();
        bus.wr_valid = '0;
        n_cmp++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL full_refill: got %0d want 16", bus.count); end
        for (int j = 2; j <= 17; j++) begin
            bus.draw_done = 1'b1;
            step();
            bus.draw_done = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                if (bus.draw_start === 1'b1) seen = 1'b1; else step();
            end
            n_cmp++; if (!seen) begin n_fail++; $display("FAIL full_drain_timeout%0d: got no draw_start want draw_start", j); end
            n_cmp++; if (cur() !== mk(j, j + 1, j + 2, j + 3)) begin n_fail++; $display("FAIL full_order%0d: got %0h want %0h", j, cur(), mk(j, j + 1, j + 2, j + 3)); end
            step();
        end
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin n_fail++; $display("FAIL full_drained: got cnt=%0d e=%b want 0 1", bus.count, bus.empty); end
    endtask

    task automatic test_clear();
        bit ok;
        apply_reset();
        for (int k = 0; k < 6; k++) push_seg(0, mk(50 + k, 60, 70, 80), ok);
        n_cmp++; if (bus.count !== 5'd5 || cur() !== mk(50, 60, 70, 80)) begin n_fail++; $display("FAIL clear_setup: got cnt=%0d %0h want 5 %0h", bus.count, cur(), mk(50, 60, 70, 80)); end
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        bus.wr_valid = 2'b01;
        bus.wr_seg[SEG_W-1:0] = mk(7, 7, 7, 7);
        #1;
        n_cmp++; if (bus.clear_active !== 1'b0 || bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL clear_pending: got ca=%b rdy=%b want 0 00", bus.clear_active, bus.wr_ready); end
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        n_cmp++; if (bus.clear_active !== 1'b0 || bus.draw_start !== 1'b0 || bus.count !== 5'd5) begin n_fail++; $display("FAIL clear_idle: got ca=%b ds=%b cnt=%0d want 0 0 5", bus.clear_active, bus.draw_start, bus.count); end
        step();
        n_cmp++; if (bus.clear_active !== 1'b1 || bus.count !== 5'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL clear_enter: got ca=%b cnt=%0d e=%b want 1 0 1", bus.clear_active, bus.count, bus.empty); end
        n_cmp++; if (bus.wr_ready !== 2'b00) begin n_fail++; $display("FAIL clear_block: got %b want 00", bus.wr_ready); end
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
        step();
        n_cmp++; if (bus.clear_active !== 1'b1 || bus.draw_start !== 1'b0) begin n_fail++; $display("FAIL clear_hold: got ca=%b ds=%b want 1 0", bus.clear_active, bus.draw_start); end
        bus.clear_done = 1'b1;
        step();
        bus.clear_done = 1'b0;
        n_cmp++; if (bus.clear_active !== 1'b0 || bus.wr_ready !== 2'b01) begin n_fail++; $display("FAIL clear_exit: got ca=%b rdy=%b want 0 01", bus.clear_active, bus.wr_ready); end
        step();
        bus.wr_valid = '0;
        n_cmp++; if (bus.count !== 5'd1 || bus.draw_start !== 1'b0) begin n_fail++; $display("FAIL clear_newpush: got cnt=%0d ds=%b want 1 0", bus.count, bus.draw_start); end
        step();
        n_cmp++; if (bus.draw_start !== 1'b1 || cur() !== mk(7, 7, 7, 7)) begin n_fail++; $display("FAIL clear_newdraw: got ds=%b %0h want 1 %0h", bus.draw_start, cur(), mk(7, 7, 7, 7)); end
        step();
        bus.draw_done = 1'b1;
        step();
        bus.draw_done = 1'b0;
    endtask

    task automatic test_reset_mid_draw();
        bit ok;
        apply_reset();
        for (int k = 0; k < 4; k++) push_seg(1, mk(200 + k, 1, 2, 3), ok);
        n_cmp++; if (bus.count !== 5'd3 || bus.draw_start !== 1'b0) begin n_fail++; $display("FAIL rmid_setup: got cnt=%0d ds=%b want 3 0", bus.count, bus.draw_start); end
        reset = 1'b1;
        step();
        n_cmp++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: got cnt=%0d e=%b f=%b want 0 1 0", bus.count, bus.empty, bus.full); end
        n_cmp++; if (cur() !== '0 || bus.draw_start !== 1'b0 || bus.clear_active !== 1'b0) begin n_fail++; $display("FAIL rmid_outs: got %0h ds=%b ca=%b want 0 0 0", cur(), bus.draw_start, bus.clear_active); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++; if (bus.draw_start !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rmid_quiet%0d: got ds=%b e=%b want 0 1", c, bus.draw_start, bus.empty); end
        end
    endtask

    task automatic test_dedup();
        bit ok1;
        bit ok2;
        apply_reset();
        push_seg(0, mk(5, 5, 9, 9), ok1);
        push_seg(0, mk(5, 5, 9, 9), ok2);
        n_cmp++; if (!ok1 || !ok2) begin n_fail++; $display("FAIL dedup_ack: got %b%b want 11", ok1, ok2); end
        n_cmp++; if (bus.count !== DUP_CNT) begin n_fail++; $display("FAIL dedup_count: got %0d want %0d", bus.count, DUP_CNT); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.wr_valid  = '0;
        bus.wr_seg    = '0;
        bus.draw_done = 1'b0;
        bus.clear_req = 1'b0;
        bus.clear_done = 1'b0;
        test_reset();
        test_basic();
        test_arbitration();
        test_full();
        test_clear();
        test_reset_mid_draw();
        test_dedup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
